seq_divider16: RTL and testbench

- Multi-cycle unsigned restoring divider for the ALU datapath.
- Sits directly downstream of the 16-bit subtractor stage. It performs one trial subtraction per clock (remainder minus divisor) and uses the borrow to choose between restoring the remainder and setting a quotient bit.
- Produces a registered quotient and remainder with a start/busy/done handshake so the control unit can stall while the divide runs.

---
 rtl/seq_divider16.sv | 108 ++++++++++
 tb/tb_seq_divider16.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/seq_divider16.sv
// Multi-cycle unsigned restoring divider: one trial subtraction per clock, with a
// start/busy/done handshake and registered quotient/remainder outputs.
module seq_divider16 #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] q_reg_q, q_reg_d;
    logic [WIDTH-1:0] prem_q, prem_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   diff;

    // Partial remainder stays below 2^(k) after k iterations, so dropping its MSB is safe.
    assign p    = {prem_q[WIDTH-2:0], q_reg_q[WIDTH-1]};
    assign diff = {1'b0, p} - {1'b0, divisor_q};

    always_comb begin
        state_d     = state_q;
        divisor_d   = divisor_q;
        q_reg_d     = q_reg_q;
        prem_d      = prem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        cnt_d       = cnt_q;

        case (state_q)
            StRun: begin
                q_reg_d = {q_reg_q[WIDTH-2:0], ~diff[WIDTH]};
                prem_d  = diff[WIDTH] ? p : diff[WIDTH-1:0];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    quotient_d  = q_reg_d;
                    remainder_d = prem_d;
                    dbz_d       = 1'b0;
                    state_d     = StDone;
                end
            end
            default: begin
                // StIdle and StDone both accept a new request.
                state_d = StIdle;
                if (start) begin
                    if (divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        state_d     = StDone;
                    end else begin
                        divisor_d = divisor;
                        q_reg_d   = dividend;
                        prem_d    = '0;
                        cnt_d     = '0;
                        state_d   = StRun;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            divisor_q   <= '0;
            q_reg_q     <= '0;
            prem_q      <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            divisor_q   <= divisor_d;
            q_reg_q     <= q_reg_d;
            prem_q      <= prem_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            cnt_q       <= cnt_d;
        end
    end

    assign busy        = (state_q == StRun);
    assign done        = (state_q == StDone);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider16.sv
// Scoreboard bench for seq_divider16: expected results are queued when a divide is
// requested and compared (values and completion cycle) when done pulses.
module tb_seq_divider16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;

    seq_divider16 #(.WIDTH(16), .CNT_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Queue the result of a request driven at the negedge where cyc == n.
    task automatic push_exp(input logic [15:0] a, input logic [15:0] b, input int unsigned n);
        exp_t e;
        if (b == 16'd0) begin
            e.q = 16'hFFFF; e.r = a; e.dbz = 1'b1; e.cyc = n + 1;
        end else begin
            e.q = a / b;    e.r = a % b; e.dbz = 1'b0; e.cyc = n + 17;
        end
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", 32'(quotient), 32'(e.q));
                check("remainder", 32'(remainder), 32'(e.r));
                check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_idle();
        bit drained = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0) begin
                drained = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!drained) begin
            check("done_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(negedge clk);
        check("done_one_pulse", 32'(done), 32'd0);
    endtask

    // Called at a negedge; returns at a negedge once the result has been compared.
    task automatic run_div(input logic [15:0] a, input logic [15:0] b);
        push_exp(a, b, cyc);
        start = 1'b1; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0;
        if (b != 16'd0) begin
            for (int i = 0; i < 16; i++) begin
                check("busy_run", 32'(busy), 32'd1);
                @(negedge clk);
            end
            check("busy_after", 32'(busy), 32'd0);
        end else begin
            check("busy_dbz", 32'(busy), 32'd0);
            check("done_dbz", 32'(done), 32'd1);
        end
        wait_idle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_q"}, 32'(quotient), 32'd0);
        check({tag, "_r"}, 32'(remainder), 32'd0);
        check({tag, "_dbz"}, 32'(div_by_zero), 32'd0);
    endtask

    initial begin
        int unsigned n;
        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_div(16'd100, 16'd7);
        run_div(16'hFFFF, 16'h0001);
        run_div(16'h8000, 16'h8000);
        run_div(16'd7, 16'd100);
        run_div(16'd5, 16'd0);
        run_div(16'hFFFF, 16'hFFFF);
        run_div(16'hFFFE, 16'hFFFF);
        run_div(16'hFFFF, 16'hC000);

        // Start while busy must be ignored.
        n = cyc;
        push_exp(16'd1000, 16'd3, n);
        start = 1'b1; dividend = 16'd1000; divisor = 16'd3;
        @(negedge clk);
        start = 1'b0;
        while (cyc < n + 5) @(negedge clk);
        start = 1'b1; dividend = 16'd9; divisor = 16'd9;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Start held through DONE: second divide begins with no idle cycle.
        n = cyc;
        push_exp(16'd50, 16'd6, n);
        push_exp(16'd50, 16'd6, n + 17);
        start = 1'b1; dividend = 16'd50; divisor = 16'd6;
        while (cyc < n + 18) @(negedge clk);
        check("b2b_busy", 32'(busy), 32'd1);
        start = 1'b0;
        wait_idle();

        // Divide-by-zero straight after a normal result, then a normal one after it.
        run_div(16'd1234, 16'd0);
        run_div(16'd1234, 16'd56);

        for (int i = 0; i < 6; i++) begin
            logic [15:0] a, b;
            a = 16'($urandom);
            b = (i % 2 == 0) ? 16'($urandom_range(1, 255)) : 16'($urandom_range(1, 65535));
            run_div(a, b);
        end

        // Asynchronous reset mid-divide discards the operation.
        n = cyc;
        start = 1'b1; dividend = 16'd40000; divisor = 16'd123;
        @(negedge clk);
        start = 1'b0;
        while (cyc < n + 8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_after_reset", 32'(busy), 32'd0);
        run_div(16'd40000, 16'd123);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d expected finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
